i2c_reg_reader: RTL and testbench

I2C_REG_READER -- requirements
Module: i2c_reg_reader

---
 rtl/i2c_reg_reader_pkg.sv | 26 ++
 rtl/i2c_stall_timer.sv | 40 ++++
 rtl/i2c_reg_reader.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_reg_reader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_reader_pkg.sv
// Shared definitions for the I2C register reader: FSM state encoding,
// error-code values reported on o_err_code, and the I2C R/W address bit.
package i2c_reg_reader_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    W_START  = 4'd1,
    W_ADDR   = 4'd2,
    W_REG    = 4'd3,
    W_WAIT   = 4'd4,
    R_START  = 4'd5,
    R_ADDR   = 4'd6,
    R_NBYTES = 4'd7,
    R_DATA   = 4'd8,
    DONE     = 4'd9,
    ERR      = 4'd10
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NAK     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_stall_timer.sv
// Stall watchdog for the register reader.
// Ports: i_clk/i_rst clock and async reset; i_clear zeroes the count;
// i_enable counts one stalled cycle; o_expired flags the stalled cycle
// that reaches TIMEOUT_CYCLES.
module i2c_stall_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expiry is the TIMEOUT_CYCLES-th consecutive stalled cycle.
  assign o_expired = i_enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Clear wins; hold at the limit so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && !o_expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_reg_reader.sv
// I2C register reader: writes a register pointer to a device, then (if
// nbytes != 0) issues a repeated-start read and streams the bytes out.
// Ports: i_clk/i_rst; command handshake (i_cmd_*, o_cmd_ready); master
// control (o_start, address, nbytes, write-data streams, read-data stream,
// i_nak); response stream (o_rsp_*); status (o_done, o_err, o_err_code).
module i2c_reg_reader
  import i2c_reg_reader_pkg::*;
#(
  parameter int unsigned DATA_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [6:0]            i_cmd_dev_addr,
  input  logic [DATA_DEPTH-1:0] i_cmd_reg_addr,
  input  logic [DATA_DEPTH-1:0] i_cmd_nbytes,
  output logic                  o_start,
  output logic [DATA_DEPTH-1:0] o_addr_bits,
  output logic                  o_addr_valid,
  input  logic                  i_addr_ready,
  output logic [DATA_DEPTH-1:0] o_nbytes_bits,
  output logic                  o_nbytes_valid,
  input  logic                  i_nbytes_ready,
  output logic [DATA_DEPTH-1:0] o_data_write_bits,
  output logic                  o_data_write_valid,
  input  logic                  i_data_write_ready,
  input  logic [DATA_DEPTH-1:0] i_data_read_bits,
  input  logic                  i_data_read_valid,
  output logic                  o_data_read_ready,
  input  logic                  i_nak,
  output logic [DATA_DEPTH-1:0] o_rsp_bits,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_last,
  output logic                  o_done,
  output logic                  o_err,
  output logic [1:0]            o_err_code
);

  state_e                state_q, state_d;
  logic [6:0]            dev_q, dev_d;
  logic [DATA_DEPTH-1:0] reg_q, reg_d;
  logic [DATA_DEPTH-1:0] nbytes_q, nbytes_d;
  logic [DATA_DEPTH-1:0] remain_q, remain_d;
  logic [1:0]            err_code_q, err_code_d;

  logic cmd_xfer, addr_xfer, nb_xfer, wr_xfer, rd_xfer, rsp_xfer, any_xfer;
  logic active, stall_expired, stall_clear, nak_abort, tmo_abort;

  assign cmd_xfer  = i_cmd_valid && o_cmd_ready;
  assign addr_xfer = o_addr_valid && i_addr_ready;
  assign nb_xfer   = o_nbytes_valid && i_nbytes_ready;
  assign wr_xfer   = o_data_write_valid && i_data_write_ready;
  assign rd_xfer   = i_data_read_valid && o_data_read_ready;
  assign rsp_xfer  = o_rsp_valid && i_rsp_ready;
  assign any_xfer  = cmd_xfer || addr_xfer || nb_xfer || wr_xfer || rd_xfer || rsp_xfer;

  // States in which NAK or a stall may abort the transaction.
  assign active = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);

  assign stall_clear = any_xfer || (state_d != state_q);

  i2c_stall_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_stall_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (stall_clear),
    .i_enable  (state_q != IDLE),
    .o_expired (stall_expired)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; aborts override normal progress, NAK before timeout.
  always_comb begin
    state_d   = state_q;
    nak_abort = 1'b0;
    tmo_abort = 1'b0;
    unique case (state_q)
      IDLE:     if (cmd_xfer)  state_d = W_START;
      W_START:                 state_d = W_ADDR;
      W_ADDR:   if (addr_xfer) state_d = W_REG;
      W_REG:    if (wr_xfer)   state_d = W_WAIT;
      W_WAIT:   if (i_addr_ready) state_d = (nbytes_q != '0) ? R_START : DONE;
      R_START:                 state_d = R_ADDR;
      R_ADDR:   if (addr_xfer) state_d = R_NBYTES;
      R_NBYTES: if (nb_xfer)   state_d = R_DATA;
      R_DATA:   if (rsp_xfer && (remain_q == DATA_DEPTH'(1))) state_d = DONE;
      DONE:                    state_d = IDLE;
      ERR:                     state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
    if (active) begin
      if (i_nak) begin
        nak_abort = 1'b1;
        state_d   = ERR;
      end else if (stall_expired && (state_d == state_q) && !rsp_xfer) begin
        tmo_abort = 1'b1;
        state_d   = ERR;
      end
    end
  end

  // Command latches, remaining-byte counter and error code.
  always_comb begin
    dev_d      = dev_q;
    reg_d      = reg_q;
    nbytes_d   = nbytes_q;
    remain_d   = remain_q;
    err_code_d = err_code_q;
    if (cmd_xfer) begin
      dev_d      = i_cmd_dev_addr;
      reg_d      = i_cmd_reg_addr;
      nbytes_d   = i_cmd_nbytes;
      err_code_d = ERR_NONE;
    end
    if (nb_xfer) begin
      remain_d = nbytes_q;
    end else if (rsp_xfer) begin
      remain_d = remain_q - DATA_DEPTH'(1);
    end
    if (nak_abort) begin
      err_code_d = ERR_NAK;
    end else if (tmo_abort) begin
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dev_q      <= '0;
      reg_q      <= '0;
      nbytes_q   <= '0;
      remain_q   <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      nbytes_q   <= nbytes_d;
      remain_q   <= remain_d;
      err_code_q <= err_code_d;
    end
  end

  assign o_err_code = err_code_q;

  // Output decode; R_DATA is a combinational pass-through to the response port.
  always_comb begin
    o_cmd_ready        = 1'b0;
    o_start            = 1'b0;
    o_addr_bits        = '0;
    o_addr_valid       = 1'b0;
    o_nbytes_bits      = '0;
    o_nbytes_valid     = 1'b0;
    o_data_write_bits  = '0;
    o_data_write_valid = 1'b0;
    o_data_read_ready  = 1'b0;
    o_rsp_bits         = '0;
    o_rsp_valid        = 1'b0;
    o_rsp_last         = 1'b0;
    o_done             = 1'b0;
    o_err              = 1'b0;
    unique case (state_q)
      IDLE:    o_cmd_ready = 1'b1;
      W_START, R_START: o_start = 1'b1;
      W_ADDR: begin
        o_addr_valid = 1'b1;
        o_addr_bits  = DATA_DEPTH'({dev_q, RW_WRITE});
      end
      W_REG: begin
        o_data_write_valid = 1'b1;
        o_data_write_bits  = reg_q;
      end
      R_ADDR: begin
        o_addr_valid = 1'b1;
        o_addr_bits  = DATA_DEPTH'({dev_q, RW_READ});
      end
      R_NBYTES: begin
        o_nbytes_valid = 1'b1;
        o_nbytes_bits  = nbytes_q;
      end
      R_DATA: begin
        o_rsp_bits        = i_data_read_bits;
        o_rsp_valid       = i_data_read_valid && !i_nak;
        o_data_read_ready = i_rsp_ready;
        o_rsp_last        = (remain_q == DATA_DEPTH'(1));
      end
      DONE:    o_done = 1'b1;
      ERR:     o_err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_reg_reader.sv
// Directed bench for i2c_reg_reader with a small I2C-master stand-in that
// logs every stream beat and serves read bytes from a table.
module tb_i2c_reg_reader;
  import i2c_reg_reader_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [6:0]    i_cmd_dev_addr = '0;
  logic [DW-1:0] i_cmd_reg_addr = '0;
  logic [DW-1:0] i_cmd_nbytes = '0;
  logic          o_start;
  logic [DW-1:0] o_addr_bits;
  logic          o_addr_valid;
  logic          i_addr_ready = 1'b1;
  logic [DW-1:0] o_nbytes_bits;
  logic          o_nbytes_valid;
  logic          i_nbytes_ready = 1'b1;
  logic [DW-1:0] o_data_write_bits;
  logic          o_data_write_valid;
  logic          i_data_write_ready = 1'b1;
  logic [DW-1:0] i_data_read_bits;
  logic          i_data_read_valid;
  logic          o_data_read_ready;
  logic          i_nak = 1'b0;
  logic [DW-1:0] o_rsp_bits;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b1;
  logic          o_rsp_last;
  logic          o_done;
  logic          o_err;
  logic [1:0]    o_err_code;

  i2c_reg_reader #(.DATA_DEPTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_dev_addr(i_cmd_dev_addr), .i_cmd_reg_addr(i_cmd_reg_addr),
    .i_cmd_nbytes(i_cmd_nbytes), .o_start(o_start),
    .o_addr_bits(o_addr_bits), .o_addr_valid(o_addr_valid), .i_addr_ready(i_addr_ready),
    .o_nbytes_bits(o_nbytes_bits), .o_nbytes_valid(o_nbytes_valid), .i_nbytes_ready(i_nbytes_ready),
    .o_data_write_bits(o_data_write_bits), .o_data_write_valid(o_data_write_valid),
    .i_data_write_ready(i_data_write_ready),
    .i_data_read_bits(i_data_read_bits), .i_data_read_valid(i_data_read_valid),
    .o_data_read_ready(o_data_read_ready), .i_nak(i_nak),
    .o_rsp_bits(o_rsp_bits), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_last(o_rsp_last), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  // Read-byte source: bytes rd_idx..rd_end-1 are pending.
  logic [7:0] rd_data [0:511];
  int rd_idx = 0;
  int rd_end = 0;
  assign i_data_read_valid = (rd_idx < rd_end);
  assign i_data_read_bits  = rd_data[rd_idx[8:0]];

  // Beat logs and pulse counters.
  logic [7:0] addr_log [0:511];
  logic [7:0] wr_log   [0:511];
  logic [7:0] nb_log   [0:511];
  logic [7:0] rsp_log  [0:511];
  int addr_n = 0, wr_n = 0, nb_n = 0, rsp_n = 0, last_n = 0, last_at = 0;
  int start_n = 0, done_n = 0, err_n = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (o_addr_valid && i_addr_ready) begin
        addr_log[addr_n[8:0]] <= o_addr_bits;
        addr_n <= addr_n + 1;
      end
      if (o_data_write_valid && i_data_write_ready) begin
        wr_log[wr_n[8:0]] <= o_data_write_bits;
        wr_n <= wr_n + 1;
      end
      if (o_nbytes_valid && i_nbytes_ready) begin
        nb_log[nb_n[8:0]] <= o_nbytes_bits;
        nb_n <= nb_n + 1;
      end
      if (o_rsp_valid && i_rsp_ready) begin
        rsp_log[rsp_n[8:0]] <= o_rsp_bits;
        rsp_n <= rsp_n + 1;
        if (o_rsp_last) begin
          last_n  <= last_n + 1;
          last_at <= rsp_n;
        end
      end
      if (i_data_read_valid && o_data_read_ready) rd_idx <= rd_idx + 1;
      if (o_start) start_n <= start_n + 1;
      if (o_done)  done_n  <= done_n + 1;
      if (o_err)   err_n   <= err_n + 1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ix(input int i);
    return i[8:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] nb);
    i_cmd_dev_addr = dev;
    i_cmd_reg_addr = rg;
    i_cmd_nbytes   = nb;
    i_cmd_valid    = 1'b1;
    check_eq("cmd_ready_idle", o_cmd_ready, 1);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int max);
    int d0, e0, c;
    d0 = done_n;
    e0 = err_n;
    c  = 0;
    while (done_n == d0 && err_n == e0 && c < max) begin
      tick();
      c++;
    end
    check_eq({tag, "_in_time"}, c < max, 1);
  endtask

  task automatic load_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int n);
    logic [7:0] v [0:3];
    v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3;
    for (int i = 0; i < n; i++) rd_data[ix(rd_end + i)] = v[i];
    rd_end = rd_end + n;
  endtask

  int ab, wb, nbb, rb, lb, sb, db, eb, t;

  task automatic snap();
    ab = addr_n; wb = wr_n; nbb = nb_n; rb = rsp_n; lb = last_n;
    sb = start_n; db = done_n; eb = err_n;
  endtask

  initial begin
    // Reset state.
    #1;
    check_eq("rst_cmd_ready", o_cmd_ready, 1);
    check_eq("rst_start", o_start, 0);
    check_eq("rst_addr_valid", o_addr_valid, 0);
    check_eq("rst_rsp_valid", o_rsp_valid, 0);
    check_eq("rst_err_code", o_err_code, 0);
    check_eq("rst_done_err", {o_done, o_err}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Two-byte read from dev 0x48, reg 0x0F.
    snap();
    load_bytes(8'hA5, 8'h5A, 8'h00, 8'h00, 2);
    send_cmd(7'h48, 8'h0F, 8'd2);
    check_eq("busy_cmd_ready", o_cmd_ready, 0);
    check_eq("w_start_pulse", o_start, 1);
    wait_end("rd2", 100);
    check_eq("rd2_addr_n", addr_n - ab, 2);
    check_eq("rd2_addr0", addr_log[ix(ab)], 8'h90);
    check_eq("rd2_addr1", addr_log[ix(ab + 1)], 8'h91);
    check_eq("rd2_wr", wr_log[ix(wb)], 8'h0F);
    check_eq("rd2_nbytes", nb_log[ix(nbb)], 8'd2);
    check_eq("rd2_rsp_n", rsp_n - rb, 2);
    check_eq("rd2_rsp0", rsp_log[ix(rb)], 8'hA5);
    check_eq("rd2_rsp1", rsp_log[ix(rb + 1)], 8'h5A);
    check_eq("rd2_last_n", last_n - lb, 1);
    check_eq("rd2_last_at", last_at - rb, 1);
    check_eq("rd2_starts", start_n - sb, 2);
    check_eq("rd2_done", done_n - db, 1);
    check_eq("rd2_err_code", o_err_code, 0);
    check_eq("rd2_idle", o_cmd_ready, 1);

    // Pointer write only.
    snap();
    send_cmd(7'h48, 8'h10, 8'd0);
    wait_end("ptr", 100);
    check_eq("ptr_starts", start_n - sb, 1);
    check_eq("ptr_addr_n", addr_n - ab, 1);
    check_eq("ptr_addr0", addr_log[ix(ab)], 8'h90);
    check_eq("ptr_wr", wr_log[ix(wb)], 8'h10);
    check_eq("ptr_nb_n", nb_n - nbb, 0);
    check_eq("ptr_rsp_n", rsp_n - rb, 0);
    check_eq("ptr_done", done_n - db, 1);

    // NAK during the read address phase.
    snap();
    send_cmd(7'h48, 8'h22, 8'd1);
    t = 0;
    while (!(o_addr_valid && o_addr_bits == 8'h91) && t < 20) begin
      tick();
      t++;
    end
    check_eq("nak_reach_raddr", t < 20, 1);
    i_nak = 1'b1;
    tick();
    i_nak = 1'b0;
    check_eq("nak_err_pulse", o_err, 1);
    check_eq("nak_code", o_err_code, ERR_NAK);
    tick();
    check_eq("nak_idle", o_cmd_ready, 1);
    check_eq("nak_err_single", o_err, 0);
    check_eq("nak_code_held", o_err_code, ERR_NAK);
    check_eq("nak_rsp_n", rsp_n - rb, 0);
    check_eq("nak_done", done_n - db, 0);
    check_eq("nak_err_n", err_n - eb, 1);

    // Timeout: address stream never accepted.
    snap();
    i_addr_ready = 1'b0;
    send_cmd(7'h48, 8'h01, 8'd1);
    check_eq("tmo_code_cleared", o_err_code, ERR_NONE);
    t = 0;
    while (!o_addr_valid && t < 10) begin
      tick();
      t++;
    end
    check_eq("tmo_reach_waddr", t < 10, 1);
    t = 0;
    while (!o_err && t < 40) begin
      tick();
      t++;
    end
    check_eq("tmo_cycles", t, TMO);
    check_eq("tmo_code", o_err_code, ERR_TIMEOUT);
    i_addr_ready = 1'b1;
    tick();
    check_eq("tmo_idle", o_cmd_ready, 1);
    check_eq("tmo_done", done_n - db, 0);

    // Four-byte read with response backpressure toggling.
    snap();
    load_bytes(8'h11, 8'h22, 8'h33, 8'h44, 4);
    send_cmd(7'h48, 8'h30, 8'd4);
    t = 0;
    while (done_n == db && t < 60) begin
      tick();
      i_rsp_ready = ~i_rsp_ready;
      #1;
      if (o_rsp_valid) check_eq("bp_mirror", o_data_read_ready, i_rsp_ready);
      t++;
    end
    i_rsp_ready = 1'b1;
    check_eq("bp_in_time", t < 60, 1);
    check_eq("bp_rsp_n", rsp_n - rb, 4);
    check_eq("bp_rsp0", rsp_log[ix(rb)], 8'h11);
    check_eq("bp_rsp1", rsp_log[ix(rb + 1)], 8'h22);
    check_eq("bp_rsp2", rsp_log[ix(rb + 2)], 8'h33);
    check_eq("bp_rsp3", rsp_log[ix(rb + 3)], 8'h44);
    tick();
    check_eq("bp_done", done_n - db, 1);

    // Reset in R_DATA after the first byte.
    snap();
    load_bytes(8'hC1, 8'hC2, 8'h00, 8'h00, 2);
    send_cmd(7'h48, 8'h40, 8'd2);
    t = 0;
    while (rsp_n == rb && t < 30) begin
      tick();
      t++;
    end
    check_eq("rr_first_byte", t < 30, 1);
    check_eq("rr_pre_valid", o_rsp_valid, 1);
    rst = 1'b1;
    rd_end = rd_idx;
    #1;
    check_eq("rr_rsp_valid", o_rsp_valid, 0);
    check_eq("rr_valids", {o_addr_valid, o_nbytes_valid, o_data_write_valid}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("rr_cmd_ready", o_cmd_ready, 1);
    check_eq("rr_no_done_err", {done_n - db, err_n - eb}, 0);
    check_eq("rr_err_code", o_err_code, 0);
    snap();
    load_bytes(8'h77, 8'h00, 8'h00, 8'h00, 1);
    send_cmd(7'h48, 8'h41, 8'd1);
    wait_end("rr_next", 100);
    check_eq("rr_next_rsp_n", rsp_n - rb, 1);
    check_eq("rr_next_rsp0", rsp_log[ix(rb)], 8'h77);
    check_eq("rr_next_done", done_n - db, 1);

    // Maximum length read.
    snap();
    for (int i = 0; i < 255; i++) rd_data[ix(rd_end + i)] = 8'(i);
    rd_end = rd_end + 255;
    send_cmd(7'h48, 8'h00, 8'd255);
    wait_end("max", 600);
    check_eq("max_nbytes", nb_log[ix(nbb)], 8'hFF);
    check_eq("max_rsp_n", rsp_n - rb, 255);
    check_eq("max_rsp_first", rsp_log[ix(rb)], 8'h00);
    check_eq("max_rsp_final", rsp_log[ix(rb + 254)], 8'hFE);
    check_eq("max_last_n", last_n - lb, 1);
    check_eq("max_last_at", last_at - rb, 254);
    check_eq("max_done", done_n - db, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
